branch_resolve_unit: RTL

Parametrised, registered successor to the ID-stage branch condition logic. It decodes every MIPS conditional branch (BEQ, BNE, BGTZ, BLEZ, and the REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL), computes the zero/negative conditions itself from the register operands, and computes the branch target. A small FSM sequences the optional delay slot, the IF/ID flush and the PC redirect. It also issues the $31 link write and keeps saturating taken/not-taken statistics counters.

---
 rtl/branch_resolve_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decodes MIPS conditional branches in ID, resolves the
// condition from the register operands, computes the target and sequences the
// optional delay slot, IF/ID flush, PC redirect and $31 link write. It also
// keeps saturating taken/not-taken statistics.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_i, stall_i    branch candidate present / pipeline stall
//   flush_i             abort from a later stage, cancels pending redirect
//   opcode_i, rt_i,     instruction fields [31:26], [20:16], [15:0]
//   offset_i
//   op_a_i, op_b_i      rs / rt register values
//   pc_i                PC of the branch
//   busy_o              unit not idle
//   taken_o, target_o   registered decision and target, held until next accept
//   illegal_o           one-cycle pulse for unsupported encodings
//   redirect_o          one-cycle PC-load pulse
//   if_id_flush_o       one-cycle IF/ID flush, coincident with redirect_o
//   link_we_o           one-cycle $31 write pulse
//   link_addr_o         constant 31
//   link_data_o         registered pc_i+8
//   taken_cnt_o         saturating taken counter
//   nt_cnt_o            saturating not-taken counter
module branch_resolve_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [5:0]        opcode_i,
  input  logic [4:0]        rt_i,
  input  logic [15:0]       offset_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              busy_o,
  output logic              taken_o,
  output logic              illegal_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              redirect_o,
  output logic              if_id_flush_o,
  output logic              link_we_o,
  output logic [4:0]        link_addr_o,
  output logic [ADDR_W-1:0] link_data_o,
  output logic [CNT_W-1:0]  taken_cnt_o,
  output logic [CNT_W-1:0]  nt_cnt_o
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [4:0] LINK_REG  = 5'd31;

  // Target arithmetic is done at least 18 bits wide so the shifted offset
  // keeps its sign even for narrow PCs; the result wraps to ADDR_W.
  localparam int unsigned EXT_W = (ADDR_W > 18) ? ADDR_W : 18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_SLOT,
    S_REDIRECT
  } state_e;

  state_e state_q, state_d;

  logic              accept_c;
  logic              is_branch_c;
  logic              taken_c;
  logic              illegal_c;
  logic              link_c;
  logic              zero_c;
  logic              neg_c;
  logic [EXT_W-1:0]  off_ext_c;
  logic [EXT_W-1:0]  sum_c;
  logic [ADDR_W-1:0] target_c;
  logic [ADDR_W-1:0] link_data_c;

  logic              taken_q;
  logic              illegal_q;
  logic              link_we_q;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] link_data_q;
  logic [CNT_W-1:0]  taken_cnt_q;
  logic [CNT_W-1:0]  nt_cnt_q;

  // Branch decode and condition evaluation.
  always_comb begin
    is_branch_c = 1'b0;
    taken_c     = 1'b0;
    illegal_c   = 1'b0;
    link_c      = 1'b0;
    // BEQ/BNE compare the two operands; all other forms compare rs against zero.
    zero_c      = ((opcode_i == OP_BEQ) || (opcode_i == OP_BNE)) ?
                  (op_a_i == op_b_i) : (op_a_i == '0);
    neg_c       = op_a_i[DATA_W-1];
    case (opcode_i)
      OP_BEQ: begin
        is_branch_c = 1'b1;
        taken_c     = zero_c;
      end
      OP_BNE: begin
        is_branch_c = 1'b1;
        taken_c     = !zero_c;
      end
      OP_BGTZ: begin
        is_branch_c = 1'b1;
        if (rt_i != 5'd0) illegal_c = 1'b1;
        else              taken_c   = !zero_c && !neg_c;
      end
      OP_BLEZ: begin
        is_branch_c = 1'b1;
        if (rt_i != 5'd0) illegal_c = 1'b1;
        else              taken_c   = zero_c || neg_c;
      end
      OP_REGIMM: begin
        is_branch_c = 1'b1;
        case (rt_i)
          RT_BLTZ:   taken_c = neg_c;
          RT_BGEZ:   taken_c = !neg_c;
          RT_BLTZAL: begin
            taken_c = neg_c;
            link_c  = 1'b1;
          end
          RT_BGEZAL: begin
            taken_c = !neg_c;
            link_c  = 1'b1;
          end
          default:   illegal_c = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // Target = pc + 4 + sext(offset) << 2, and link data = pc + 8.
  always_comb begin
    off_ext_c   = EXT_W'($signed({offset_i, 2'b00}));
    sum_c       = EXT_W'(pc_i) + off_ext_c + EXT_W'(4);
    target_c    = ADDR_W'(sum_c);
    link_data_c = pc_i + ADDR_W'(8);
  end

  // Next-state logic; flush_i always returns to IDLE and blocks acceptance.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !stall_i && is_branch_c) begin
          accept_c = 1'b1;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        if (taken_q) state_d = (DELAY_SLOT != 0) ? S_SLOT : S_REDIRECT;
        else         state_d = S_IDLE;
      end
      S_SLOT: begin
        if (!stall_i) state_d = S_REDIRECT;
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      accept_c = 1'b0;
    end
  end

  // State, decision capture, pulses and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      link_we_q   <= 1'b0;
      target_q    <= '0;
      link_data_q <= '0;
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept_c && illegal_c;
      link_we_q <= accept_c && link_c;
      if (accept_c) begin
        taken_q     <= taken_c;
        target_q    <= target_c;
        link_data_q <= link_data_c;
      end
      // EVAL always lasts one cycle, so this is the EVAL exit edge.
      if (state_q == S_EVAL) begin
        if (taken_q) begin
          if (taken_cnt_q != {CNT_W{1'b1}}) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
        end else begin
          if (nt_cnt_q != {CNT_W{1'b1}}) nt_cnt_q <= nt_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign taken_o       = taken_q;
  assign illegal_o     = illegal_q;
  assign target_o      = target_q;
  assign link_we_o     = link_we_q;
  assign link_addr_o   = LINK_REG;
  assign link_data_o   = link_data_q;
  assign taken_cnt_o   = taken_cnt_q;
  assign nt_cnt_o      = nt_cnt_q;
  // A late-stage flush must be able to kill the redirect in the same cycle.
  assign redirect_o    = (state_q == S_REDIRECT) && !flush_i;
  assign if_id_flush_o = (state_q == S_REDIRECT) && !flush_i;

endmodule
